// File: rtl/alu_seq_32_pkg.sv
// Shared opcode and state encodings for the sequential ALU stage.
package alu_seq_32_pkg;

  typedef enum logic [2:0] {
    ALU_AND = 3'd0,
    ALU_OR  = 3'd1,
    ALU_XOR = 3'd2,
    ALU_ADD = 3'd3,
    ALU_SUB = 3'd4,
    ALU_SLT = 3'd5,
    ALU_SLL = 3'd6,
    ALU_SRL = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } alu_state_e;

  function automatic logic is_shift(input logic [2:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL);
  endfunction

endpackage

// File: rtl/alu_seq_32_xor.sv
// Purpose: 32-bit bitwise XOR built from per-bit gates; zero latency.
// Backpressure: none, purely combinational.
module xor_32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_y
);

  for (genvar g = 0; g < 32; g++) begin : g_bit
    xor u_xor (o_y[g], i_a[g], i_b[g]);
  end

endmodule

// File: rtl/alu_seq_32.sv
// Purpose: multi-cycle ALU; logic/arith done 1 cycle after start, shifts take shamt cycles.
// Backpressure: start is only accepted in IDLE; requests while busy or in DONE are dropped.
module alu_seq_32
  import alu_seq_32_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  alu_state_e       r_state;
  alu_state_e       w_next_state;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_work;
  logic [4:0]       r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_ovf;

  logic [WIDTH-1:0] w_xor;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_add_ovf;
  logic             w_sub_ovf;
  logic             w_lt;
  logic [WIDTH-1:0] w_exec_res;
  logic             w_exec_ovf;
  logic [WIDTH-1:0] w_work_nxt;

  xor_32 u_xor_32 (
    .i_a (r_a),
    .i_b (r_b),
    .o_y (w_xor)
  );

  assign w_sum     = r_a + r_b;
  assign w_diff    = r_a - r_b;
  assign w_add_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1]  != r_a[WIDTH-1]);
  assign w_sub_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
  assign w_lt      = w_diff[WIDTH-1] ^ w_sub_ovf;

  // Shifts only reach EXEC with shamt==0, so they pass operand A through.
  always_comb begin
    w_exec_res = '0;
    w_exec_ovf = 1'b0;
    case (r_op)
      ALU_AND: w_exec_res = r_a & r_b;
      ALU_OR:  w_exec_res = r_a | r_b;
      ALU_XOR: w_exec_res = w_xor;
      ALU_ADD: begin
        w_exec_res = w_sum;
        w_exec_ovf = w_add_ovf;
      end
      ALU_SUB: begin
        w_exec_res = w_diff;
        w_exec_ovf = w_sub_ovf;
      end
      ALU_SLT: w_exec_res = {{(WIDTH-1){1'b0}}, w_lt};
      default: w_exec_res = r_a;
    endcase
  end

  assign w_work_nxt = (r_op == ALU_SRL) ? (r_work >> 1) : (r_work << 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next_state = (is_shift(alu_op) && (in2[4:0] != 5'd0)) ? ST_SHIFT : ST_EXEC;
        end
      end
      ST_EXEC:  w_next_state = ST_DONE;
      ST_SHIFT: if (r_cnt == 5'd1) w_next_state = ST_DONE;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      ST_EXEC, ST_SHIFT: busy = 1'b1;
      ST_DONE:           done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_work   <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_op   <= alu_op;
            r_a    <= in1;
            r_b    <= in2;
            r_work <= in1;
            r_cnt  <= in2[4:0];
          end
        end
        ST_EXEC: begin
          r_result <= w_exec_res;
          r_zero   <= (w_exec_res == '0);
          r_ovf    <= w_exec_ovf;
        end
        ST_SHIFT: begin
          r_work <= w_work_nxt;
          r_cnt  <= r_cnt - 5'd1;
          if (r_cnt == 5'd1) begin
            r_result <= w_work_nxt;
            r_zero   <= (w_work_nxt == '0);
            r_ovf    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign result   = r_result;
  assign zero     = r_zero;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_alu_seq_32.sv
// Scoreboard bench for alu_seq_32: directed vectors push expected results,
// a negedge monitor pops and checks them whenever done pulses.
module tb_alu_seq_32;
  import alu_seq_32_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  alu_op;
  logic [31:0] in1;
  logic [31:0] in2;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic        busy;
  logic        done;

  alu_seq_32 #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .alu_op   (alu_op),
    .in1      (in1),
    .in2      (in2),
    .result   (result),
    .zero     (zero),
    .overflow (overflow),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        ov;
    int          due;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic prev_done = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset) begin
      prev_done <= 1'b0;
    end else begin
      if (prev_done) chk("done_one_cycle", {31'b0, done}, 32'd0);
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", {31'b0, done}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk({e.name, "_result"},   result,           e.res);
          chk({e.name, "_zero"},     {31'b0, zero},     {31'b0, e.z});
          chk({e.name, "_overflow"}, {31'b0, overflow}, {31'b0, e.ov});
          chk({e.name, "_latency"},  cyc,              e.due);
        end
      end
      prev_done <= done;
    end
  end

  // Called just after a negedge; returns just after the negedge where the DUT is back in IDLE.
  task automatic go(input string nm, input logic [2:0] op, input logic [31:0] a,
                    input logic [31:0] b, input logic [31:0] res, input logic z,
                    input logic ov, input int lat, input bit pulse);
    bit seen;
    exp_t e;
    start  = 1'b1;
    alu_op = op;
    in1    = a;
    in2    = b;
    e.res = res; e.z = z; e.ov = ov; e.due = cyc + 1 + lat; e.name = nm;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk({nm, "_busy"}, {31'b0, busy}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (pulse) begin
          start  = (i % 3 == 0);
          alu_op = ALU_ADD;
          in1    = 32'hDEAD_BEEF;
          in2    = 32'h0000_0003;
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
    chk({nm, "_done_seen"}, {31'b0, seen}, 32'd1);
    @(negedge clk);
    chk({nm, "_idle_busy"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    alu_op = 3'd0;
    in1    = '0;
    in2    = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_result",   result,            32'd0);
    chk("rst_zero",     {31'b0, zero},     32'd1);
    chk("rst_overflow", {31'b0, overflow}, 32'd0);
    chk("rst_busy",     {31'b0, busy},     32'd0);
    chk("rst_done",     {31'b0, done},     32'd0);

    // Back-to-back directed vectors with hand-computed expectations.
    go("xor_a",   ALU_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0, 1'b0, 1, 1'b0);
    go("xor_eq",  ALU_XOR, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0, 1, 1'b0);
    go("and",     ALU_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0, 1, 1'b0);
    go("or",      ALU_OR,  32'h0000_00F0, 32'h0F00_0000, 32'h0F00_00F0, 1'b0, 1'b0, 1, 1'b0);
    go("add_ovf", ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1, 1'b0);
    go("add_wrap",ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1, 1'b0);
    go("sub_ovf", ALU_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1, 1'b0);
    go("sub_neg", ALU_SUB, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0, 1, 1'b0);
    go("slt_neg", ALU_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1, 1'b0);
    go("slt_ovf", ALU_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0, 1, 1'b0);
    go("sll_31",  ALU_SLL, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0, 1'b0, 31, 1'b1);
    go("srl_0",   ALU_SRL, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0, 1, 1'b0);
    go("srl_4",   ALU_SRL, 32'hF000_0000, 32'h0000_0004, 32'h0F00_0000, 1'b0, 1'b0, 4, 1'b1);
    go("sll_1",   ALU_SLL, 32'h0000_0003, 32'h0000_0021, 32'h0000_0006, 1'b0, 1'b0, 1, 1'b0);
    go("sll_out", ALU_SLL, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1, 1'b0);

    // Reset lands on E0+3 of a shift by 8: the operation must vanish.
    start  = 1'b1;
    alu_op = ALU_SRL;
    in1    = 32'hF000_0000;
    in2    = 32'h0000_0008;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_busy_before", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_result",   result,            32'd0);
    chk("abort_zero",     {31'b0, zero},     32'd1);
    chk("abort_overflow", {31'b0, overflow}, 32'd0);
    chk("abort_busy",     {31'b0, busy},     32'd0);
    chk("abort_done",     {31'b0, done},     32'd0);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_still_idle", {31'b0, busy}, 32'd0);

    go("add_after", ALU_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1, 1'b0);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
